// File: rtl/pulse_out_reg_pkg.sv
// pulse_out_reg_pkg: shared definitions for the monostable output register.
//   - chanState_t : per-channel state encoding (ST_IDLE / ST_PULSE / ST_HOLDOFF)
//   - cntWidth()  : counter width able to hold max(pulseCycles, holdoffCycles)
package pulse_out_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } chanState_t;

    function automatic int cntWidth(input int pulseCycles, input int holdoffCycles);
        int maxCycles;
        maxCycles = (pulseCycles > holdoffCycles) ? pulseCycles : holdoffCycles;
        return (maxCycles < 1) ? 1 : $clog2(maxCycles + 1);
    endfunction

endpackage

// File: rtl/pulse_out_channel.sv
// pulse_out_channel: one monostable channel (FSM + down-counter).
// Ports:
//   masterClk   in  1  master clock
//   reset       in  1  asynchronous, active-high reset
//   fire        in  1  single-cycle rising-edge request from the top
//   abort       in  1  synchronous kill of pulse/holdoff
//   pulseOutput out 1  registered pulse output (high for PULSE_CYCLES)
//   busy        out 1  registered, high in PULSE and HOLDOFF
// Build option: PULSE_OUT_RETRIGGER_EN -- a fire during PULSE reloads the counter.
module pulse_out_channel
    import pulse_out_reg_pkg::*;
#(
    parameter int PULSE_CYCLES   = 32,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int CNT_W          = 6
) (
    input  logic masterClk,
    input  logic reset,
    input  logic fire,
    input  logic abort,
    output logic pulseOutput,
    output logic busy
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  =
        (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

    chanState_t       state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;

    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pulseOutput <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            pulseOutput <= (stateNext == ST_PULSE);
            busy        <= (stateNext != ST_IDLE);
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            ST_IDLE: begin
                if (fire) begin
                    stateNext = ST_PULSE;
                    cntNext   = PULSE_LOAD;
                end
            end
            ST_PULSE: begin
`ifdef PULSE_OUT_RETRIGGER_EN
                if (fire)
                    cntNext = PULSE_LOAD;
                else
`endif
                if (cnt == '0) begin
                    if (HOLDOFF_CYCLES > 0) begin
                        stateNext = ST_HOLDOFF;
                        cntNext   = HOLD_LOAD;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                // Edges here are dropped, including one on the final cycle.
                if (cnt == '0)
                    stateNext = ST_IDLE;
                else
                    cntNext = cnt - 1'b1;
            end
            default: begin
                stateNext = ST_IDLE;
                cntNext   = '0;
            end
        endcase
        if (abort) begin
            stateNext = ST_IDLE;
            cntNext   = '0;
        end
    end

endmodule

// File: rtl/pulse_out_reg.sv
// pulse_out_reg: N-bit monostable output register, drive side of the latched-input path.
// Each trigger bit's rising edge launches one fixed-width active-high pulse on the
// corresponding pulseOutput bit, followed by a forced-low holdoff.
// Ports:
//   masterClk   in  1      master clock
//   reset       in  1      asynchronous, active-high reset
//   trigger     in  WIDTH  per-bit fire request (masterClk-synchronous), rising edge acts
//   abort       in  1      synchronous: kill all pulses and holdoffs
//   pulseOutput out WIDTH  registered pulse outputs
//   busy        out WIDTH  registered, channel in PULSE or HOLDOFF
// Build option: PULSE_OUT_RETRIGGER_EN -- edge during PULSE extends the pulse.
module pulse_out_reg
    import pulse_out_reg_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PULSE_CYCLES   = 32,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic             masterClk,
    input  logic             reset,
    input  logic [WIDTH-1:0] trigger,
    input  logic             abort,
    output logic [WIDTH-1:0] pulseOutput,
    output logic [WIDTH-1:0] busy
);

    localparam int CNT_W = cntWidth(PULSE_CYCLES, HOLDOFF_CYCLES);

    logic [WIDTH-1:0] prevTrigger;
    logic [WIDTH-1:0] triggerEdge;

    // Reset to all-ones so a trigger held high through reset release never fires.
    always_ff @(posedge masterClk or posedge reset) begin
        if (reset)
            prevTrigger <= '1;
        else
            prevTrigger <= trigger;
    end

    assign triggerEdge = trigger & ~prevTrigger;

    for (genvar i = 0; i < WIDTH; i++) begin : gChan
        pulse_out_channel #(
            .PULSE_CYCLES  (PULSE_CYCLES),
            .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
            .CNT_W         (CNT_W)
        ) uChan (
            .masterClk  (masterClk),
            .reset      (reset),
            .fire       (triggerEdge[i]),
            .abort      (abort),
            .pulseOutput(pulseOutput[i]),
            .busy       (busy[i])
        );
    end

endmodule
